// File: rtl/isa_bus_pkg.sv
// ---------------------------------------------------------------------------
// isa_bus_pkg
// Shared definitions for the ISA I/O cycle sequencer:
//   - state_t        : FSM state encoding (also the value seen on state_debug)
//   - TIMEOUT_RDATA  : read data returned when IOCHRDY times out (all ones)
//   - cnt_width()    : width of the shared timing counter
// ---------------------------------------------------------------------------
package isa_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RECOVER = 3'd3
  } state_t;

  // Wide enough for any supported DATA_W; the sequencer slices what it needs.
  localparam int                  MAX_DATA_W    = 64;
  localparam logic [MAX_DATA_W-1:0] TIMEOUT_RDATA = '1;

  // One counter serves setup, strobe, extension and recovery timing, so it is
  // sized for the largest of the four parameters plus one bit of headroom.
  function automatic int cnt_width(input int a, input int b,
                                   input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous level. Resets to 1 so a
// ready-style input reads as "ready" until real samples have propagated.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high reset
//   d      in  asynchronous input
//   q      out synchronised output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/isa_bus_sequencer.sv
// ---------------------------------------------------------------------------
// isa_bus_sequencer
// ISA I/O cycle generator with programmable setup / strobe / recovery timing
// and IOCHRDY wait extension with timeout.
//
// Command handshake: a command transfers on a rising clk edge where
// cmd_valid and cmd_ready are both high. cmd_ready is high only while IDLE;
// all command fields are latched on that edge. cmd_valid while busy is
// ignored (nothing is queued). Each accepted command produces exactly one
// rsp_valid pulse unless aborted by reset.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_write, cmd_wide        1=write/0=read, 1=16-bit cycle (0 if DATA_W=8)
//   cmd_addr, cmd_wdata        I/O address and write data
//   rsp_valid                  one-cycle completion pulse
//   rsp_rdata, rsp_timeout     read data (held), timeout flag with rsp_valid
//   isa_addr, isa_data_out     registered bus address / write data
//   isa_data_oe                drive isa_data_out onto the bus
//   isa_data_in                bus read data
//   isa_ior_n, isa_iow_n       I/O strobes, active low
//   isa_sbhe_n                 byte-high enable, low for wide cycles
//   isa_iochrdy                asynchronous card ready (0 = extend)
//   state_debug                current FSM state (IDLE=0 .. RECOVER=3)
// ---------------------------------------------------------------------------
module isa_bus_sequencer
  import isa_bus_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 3,
  parameter int RECOVERY_CYC = 1,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_wide,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] isa_addr,
  output logic [DATA_W-1:0] isa_data_out,
  output logic              isa_data_oe,
  input  logic [DATA_W-1:0] isa_data_in,
  output logic              isa_ior_n,
  output logic              isa_iow_n,
  output logic              isa_sbhe_n,
  input  logic              isa_iochrdy,
  output logic [2:0]        state_debug
);

  localparam int CNT_W = cnt_width(SETUP_CYC, STROBE_CYC, RECOVERY_CYC, TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] SETUP_LAST    = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST   = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] RECOVERY_LAST = CNT_W'(RECOVERY_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam bit               WIDE_OK       = (DATA_W > 8);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ext;        // strobe is past its minimum, counting extra cycles
  logic                r_write;
  logic                r_wide;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic                r_rsp_timeout;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_data_oe;
  logic                r_ior_n;
  logic                r_iow_n;
  logic                r_sbhe_n;

  logic                w_iochrdy_s;
  logic                w_wide;
  logic [DATA_W-1:0]   w_narrow_mask;
  logic                w_min_done;
  logic                w_exit_ready;
  logic                w_exit_to;
  logic [DATA_W-1:0]   w_rd_capture;

  sync_2ff u_sync_iochrdy (
    .clk   (clk),
    .reset (reset),
    .d     (isa_iochrdy),
    .q     (w_iochrdy_s)
  );

  assign w_wide = WIDE_OK & cmd_wide;

  always_comb begin
    w_narrow_mask      = '0;
    w_narrow_mask[7:0] = '1;
  end

  // Ready is only looked at from the last minimum strobe cycle onwards.
  // While extending, r_cnt holds the number of the current extra cycle, so
  // reaching TIMEOUT_CYC without ready ends the strobe with a timeout.
  assign w_min_done   = r_ext || (r_cnt == '0);
  assign w_exit_ready = w_min_done && w_iochrdy_s;
  assign w_exit_to    = r_ext && !w_iochrdy_s && (r_cnt == TIMEOUT_LAST);

  always_comb begin
    if (w_exit_to)
      w_rd_capture = TIMEOUT_RDATA[DATA_W-1:0];
    else if (r_wide)
      w_rd_capture = isa_data_in;
    else
      w_rd_capture = isa_data_in & w_narrow_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_ext         <= 1'b0;
      r_write       <= 1'b0;
      r_wide        <= 1'b0;
      r_cmd_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
      r_addr        <= '0;
      r_data_out    <= '0;
      r_data_oe     <= 1'b0;
      r_ior_n       <= 1'b1;
      r_iow_n       <= 1'b1;
      r_sbhe_n      <= 1'b1;
    end else begin
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_state     <= ST_ADDR;
            r_cmd_ready <= 1'b0;
            r_write     <= cmd_write;
            r_wide      <= w_wide;
            r_addr      <= cmd_addr;
            r_data_out  <= cmd_wdata;
            r_data_oe   <= cmd_write;   // data on the bus before IOW# falls
            r_sbhe_n    <= ~w_wide;
            r_cnt       <= SETUP_LAST;
          end
        end
        ST_ADDR: begin
          if (r_cnt == '0) begin
            r_state <= ST_STROBE;
            r_ior_n <= r_write;
            r_iow_n <= ~r_write;
            r_cnt   <= STROBE_LAST;
            r_ext   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_STROBE: begin
          if (w_exit_ready || w_exit_to) begin
            r_state       <= ST_RECOVER;
            r_ior_n       <= 1'b1;
            r_iow_n       <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= w_exit_to;
            r_cnt         <= RECOVERY_LAST;
            r_ext         <= 1'b0;
            if (!r_write) r_rsp_rdata <= w_rd_capture;
          end else if (!r_ext) begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CNT_ONE;
            end else begin
              r_ext <= 1'b1;
              r_cnt <= CNT_ONE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_RECOVER: begin
          // Write data stays driven through the first recovery cycle (hold time).
          r_data_oe <= 1'b0;
          if (r_cnt == '0) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_sbhe_n    <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
          r_ior_n     <= 1'b1;
          r_iow_n     <= 1'b1;
          r_data_oe   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_timeout  = r_rsp_timeout;
  assign isa_addr     = r_addr;
  assign isa_data_out = r_data_out;
  assign isa_data_oe  = r_data_oe;
  assign isa_ior_n    = r_ior_n;
  assign isa_iow_n    = r_iow_n;
  assign isa_sbhe_n   = r_sbhe_n;
  assign state_debug  = r_state;

endmodule

// File: tb/tb_isa_bus_sequencer.sv
module tb_isa_bus_sequencer;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic              cmd_wide;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] isa_addr;
  logic [DATA_W-1:0] isa_data_out;
  logic              isa_data_oe;
  logic [DATA_W-1:0] isa_data_in;
  logic              isa_ior_n;
  logic              isa_iow_n;
  logic              isa_sbhe_n;
  logic              isa_iochrdy;
  logic [2:0]        state_debug;

  isa_bus_sequencer #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .SETUP_CYC    (1),
    .STROBE_CYC   (3),
    .RECOVERY_CYC (1),
    .TIMEOUT_CYC  (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_wide     (cmd_wide),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_timeout  (rsp_timeout),
    .isa_addr     (isa_addr),
    .isa_data_out (isa_data_out),
    .isa_data_oe  (isa_data_oe),
    .isa_data_in  (isa_data_in),
    .isa_ior_n    (isa_ior_n),
    .isa_iow_n    (isa_iow_n),
    .isa_sbhe_n   (isa_sbhe_n),
    .isa_iochrdy  (isa_iochrdy),
    .state_debug  (state_debug)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard entry: [17] compare rdata, [16] timeout flag, [15:0] read data.
  logic [17:0] exp_q[$];
  logic [17:0] sb_e;

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        sb_e = exp_q.pop_front();
        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, sb_e[16]});
        if (sb_e[17]) chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, sb_e[15:0]});
      end
    end
  end

  // ---------------- vector table ----------------
  // rdy_raise: 0 = iochrdy held high; N>0 = iochrdy low from before the
  // command until the N-th strobe-low cycle; -1 = iochrdy stuck low.
  typedef struct {
    logic        write;
    logic        wide;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] bus;
    int          rdy_raise;
    int          exp_strobe;
    logic        exp_to;
    logic [15:0] exp_rdata;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];

  // ---------------- driver tasks ----------------
  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_ready;
    if (!ok) chk("ready_wait", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int n, scnt;
    bit got, ok;
    if (v.rdy_raise != 0) begin
      isa_iochrdy = 1'b0;
      repeat (3) @(posedge clk);
    end
    wait_ready(ok);
    if (ok) begin
      isa_data_in = v.bus;
      cmd_valid   = 1'b1;
      cmd_write   = v.write;
      cmd_wide    = v.wide;
      cmd_addr    = v.addr;
      cmd_wdata   = v.wdata;
      exp_q.push_back({~v.write, v.exp_to, v.exp_rdata});
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      n = 0; scnt = 0; got = 0;
      while (!got && n < 100) begin
        @(negedge clk);
        n++;
        if (n == 1) begin
          chk("addr_state", {29'd0, state_debug}, 32'd1);
          chk("addr_ready", {31'd0, cmd_ready}, 32'd0);
          chk("addr_bus", {16'd0, isa_addr}, {16'd0, v.addr});
          chk("addr_sbhe", {31'd0, isa_sbhe_n}, {31'd0, ~v.wide});
          chk("addr_oe", {31'd0, isa_data_oe}, {31'd0, v.write});
          chk("addr_strobes", {30'd0, isa_ior_n, isa_iow_n}, 32'd3);
          if (v.write) chk("addr_wdata", {16'd0, isa_data_out}, {16'd0, v.wdata});
        end
        if (n == 2) begin
          chk("strobe_state", {29'd0, state_debug}, 32'd2);
          chk("strobe_ior", {31'd0, isa_ior_n}, {31'd0, v.write});
          chk("strobe_iow", {31'd0, isa_iow_n}, {31'd0, ~v.write});
        end
        if (!isa_ior_n || !isa_iow_n) scnt++;
        if (v.rdy_raise > 0 && scnt == v.rdy_raise) isa_iochrdy = 1'b1;
        if (rsp_valid) got = 1;
      end
      if (!got) begin
        chk("rsp_wait", 32'd0, 32'd1);
      end else begin
        chk("latency", n, v.exp_strobe + 2);
        chk("strobe_len", scnt, v.exp_strobe);
        chk("recover_state", {29'd0, state_debug}, 32'd3);
        chk("recover_oe", {31'd0, isa_data_oe}, {31'd0, v.write});
        chk("recover_strobes", {30'd0, isa_ior_n, isa_iow_n}, 32'd3);
        @(negedge clk);
        chk("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
        chk("idle_oe", {31'd0, isa_data_oe}, 32'd0);
        chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_state", {29'd0, state_debug}, 32'd0);
        chk("idle_sbhe", {31'd0, isa_sbhe_n}, 32'd1);
      end
    end
    isa_iochrdy = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit ok, got;
    logic [15:0] rb;

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_wide = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; isa_data_in = '0; isa_iochrdy = 1'b1;

    vecs[0]  = '{1'b0, 1'b1, 16'h0220, 16'h0000, 16'hBEEF,  0,  3, 1'b0, 16'hBEEF};
    vecs[1]  = '{1'b1, 1'b0, 16'h0388, 16'h005A, 16'h0000,  0,  3, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 16'h0301, 16'h0000, 16'hA55A,  0,  3, 1'b0, 16'h005A};
    vecs[3]  = '{1'b1, 1'b1, 16'h0300, 16'h1234, 16'h0000,  0,  3, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 1'b1, 16'h0222, 16'h0000, 16'h1357, 11, 13, 1'b0, 16'h1357};
    vecs[5]  = '{1'b0, 1'b1, 16'h0224, 16'h0000, 16'h4242, -1, 19, 1'b1, 16'hFFFF};
    vecs[6]  = '{1'b0, 1'b1, 16'h0226, 16'h0000, 16'h0F0F,  1,  3, 1'b0, 16'h0F0F};
    vecs[7]  = '{1'b0, 1'b0, 16'h0228, 16'h0000, 16'h77C3,  2,  4, 1'b0, 16'h00C3};
    vecs[8]  = '{1'b0, 1'b1, 16'h022A, 16'h0000, 16'h2468, 16, 18, 1'b0, 16'h2468};
    rb = 16'($urandom_range(0, 16'hFFFF));
    vecs[9]  = '{1'b0, 1'b0, 16'($urandom_range(0, 16'hFFFF)), 16'h0000, rb, 0, 3, 1'b0, rb & 16'h00FF};
    vecs[10] = '{1'b1, 1'b1, 16'($urandom_range(0, 16'hFFFF)),
                 16'($urandom_range(0, 16'hFFFF)), 16'h0000, 5, 7, 1'b0, 16'h0000};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp", {30'd0, rsp_valid, rsp_timeout}, 32'd0);
    chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("rst_strobes", {29'd0, isa_ior_n, isa_iow_n, isa_sbhe_n}, 32'd7);
    chk("rst_oe", {31'd0, isa_data_oe}, 32'd0);
    chk("rst_addr", {16'd0, isa_addr}, 32'd0);
    chk("rst_dout", {16'd0, isa_data_out}, 32'd0);
    chk("rst_state", {29'd0, state_debug}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Back-to-back: cmd_valid held high across two commands
    wait_ready(ok);
    if (ok) begin
      isa_data_in = 16'h1111;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_wide = 1'b1; cmd_addr = 16'h0100;
      exp_q.push_back({1'b1, 1'b0, 16'h1111});
      n = 0; got = 0;
      while (!got && n < 20) begin
        @(negedge clk);
        n++;
        if (rsp_valid) got = 1;
      end
      chk("b2b_first_rsp", {31'd0, got}, 32'd1);
      chk("b2b_no_overlap", {31'd0, cmd_ready}, 32'd0);
      isa_data_in = 16'h2299; cmd_wide = 1'b0; cmd_addr = 16'h0102;
      exp_q.push_back({1'b1, 1'b0, 16'h0099});
      @(negedge clk);
      chk("b2b_ready_after", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("b2b_second_state", {29'd0, state_debug}, 32'd1);
      chk("b2b_second_addr", {16'd0, isa_addr}, 32'h0102);
      n = 1; got = 0;
      while (!got && n < 20) begin
        @(negedge clk);
        n++;
        if (rsp_valid) got = 1;
      end
      chk("b2b_second_latency", n, 32'd5);
      @(negedge clk);
    end

    // Reset asserted in the middle of a strobe
    wait_ready(ok);
    if (ok) begin
      isa_data_in = 16'h3333;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_wide = 1'b1; cmd_addr = 16'h0200;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (state_debug != 3'd2 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("abort_in_strobe", {31'd0, isa_ior_n}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_ior", {31'd0, isa_ior_n}, 32'd1);
      chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
      chk("abort_state", {29'd0, state_debug}, 32'd0);
      chk("abort_rsp", {31'd0, rsp_valid}, 32'd0);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      chk("abort_ior_idle", {31'd0, isa_ior_n}, 32'd1);
    end

    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
